// File: rtl/tbird_pkg.sv
// Shared types and helpers for the Thunderbird tail-light sequencer.
// Holds the state and request enums plus prescaler sizing functions.
package tbird_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEFT,
        S_RIGHT,
        S_HAZ_ON,
        S_HAZ_OFF
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_LEFT,
        REQ_RIGHT,
        REQ_HAZ
    } req_t;

    function automatic int calc_div(input int clk_hz, input int step_hz);
        int d;
        d = (step_hz > 0) ? clk_hz / step_hz : 1;
        return (d < 1) ? 1 : d;
    endfunction

    // A one-state counter still needs one bit to exist.
    function automatic int cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/tbird_prescaler.sv
// Step-enable generator: counts 0..DIV-1 and flags the last count.
// Shared by other timed blocks that need a slow enable.
module tbird_prescaler
    import tbird_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = cnt_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/tbird_sweep.sv
// Thunderbird tail-light sequencer with left/right sweeps and hazard flash.
// Optional brake input enabled by defining TBIRD_BRAKE_EN.
module tbird_sweep
    import tbird_pkg::*;
#(
    parameter int LAMPS   = 3,
    parameter int CLK_HZ  = 100_000_000,
    parameter int STEP_HZ = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
`ifdef TBIRD_BRAKE_EN
    input  logic             brake,
`endif
    output logic [LAMPS-1:0] left_lights,
    output logic [LAMPS-1:0] right_lights,
    output logic             step
);

    localparam int DIV = calc_div(CLK_HZ, STEP_HZ);
    localparam int IW  = $clog2(LAMPS + 1);

`ifdef TBIRD_BRAKE_EN
    localparam int NS = 4;
    logic [NS-1:0] pins;
    assign pins = {brake, hazard, right, left};
`else
    localparam int NS = 3;
    logic [NS-1:0] pins;
    assign pins = {hazard, right, left};
`endif

    logic [NS-1:0] meta;
    logic [NS-1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= pins;
            sync <= meta;
        end
    end

    logic l_s, r_s, h_s, b_s;
    assign l_s = sync[0];
    assign r_s = sync[1];
    assign h_s = sync[2];
`ifdef TBIRD_BRAKE_EN
    assign b_s = sync[3];
`else
    assign b_s = 1'b0;
`endif

    logic tick;

    tbird_prescaler #(.DIV(DIV)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    req_t req;

    always_comb begin
        req = REQ_NONE;
        if (h_s || (l_s && r_s)) begin
            req = REQ_HAZ;
        end else if (l_s) begin
            req = REQ_LEFT;
        end else if (r_s) begin
            req = REQ_RIGHT;
        end
    end

    state_t        state, nstate, vstate;
    logic [IW-1:0] idx, nidx, vidx;
    logic          same_dir;

    assign same_dir = (state == S_LEFT  && req == REQ_LEFT) ||
                      (state == S_RIGHT && req == REQ_RIGHT);

    always_comb begin
        nstate = state;
        nidx   = idx;
        case (state)
            S_IDLE: begin
                nidx = '0;
                case (req)
                    REQ_HAZ:   nstate = S_HAZ_ON;
                    REQ_LEFT:  begin nstate = S_LEFT;  nidx = IW'(1); end
                    REQ_RIGHT: begin nstate = S_RIGHT; nidx = IW'(1); end
                    default:   nstate = S_IDLE;
                endcase
            end
            S_LEFT, S_RIGHT: begin
                if (req == REQ_HAZ) begin
                    nstate = S_HAZ_ON;
                    nidx   = '0;
                end else if (same_dir && idx < IW'(LAMPS)) begin
                    nidx = idx + IW'(1);
                end else begin
                    nstate = S_IDLE;
                    nidx   = '0;
                end
            end
            S_HAZ_ON: begin
                nidx   = '0;
                nstate = (req == REQ_HAZ) ? S_HAZ_OFF : S_IDLE;
            end
            S_HAZ_OFF: begin
                nidx   = '0;
                nstate = (req == REQ_HAZ) ? S_HAZ_ON : S_IDLE;
            end
            default: begin
                nstate = S_IDLE;
                nidx   = '0;
            end
        endcase
    end

    // Lamps reflect the state about to be registered so brake can act every clk.
    assign vstate = tick ? nstate : state;
    assign vidx   = tick ? nidx : idx;

    logic [LAMPS-1:0] lamp_l, lamp_r;

    always_comb begin
        lamp_l = '0;
        lamp_r = '0;
        for (int i = 0; i < LAMPS; i++) begin
            lamp_l[i] = (vstate == S_LEFT) && (i < int'(vidx));
            lamp_r[i] = (vstate == S_RIGHT) && (i >= LAMPS - int'(vidx));
        end
        if (vstate == S_HAZ_ON) begin
            lamp_l = '1;
            lamp_r = '1;
        end
        if (b_s) begin
            if (vstate != S_LEFT)  lamp_r = '1;
            if (vstate != S_RIGHT) lamp_l = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            step         <= 1'b0;
            left_lights  <= '0;
            right_lights <= '0;
        end else begin
            if (tick) begin
                state <= nstate;
                idx   <= nidx;
            end
            step         <= tick;
            left_lights  <= lamp_l;
            right_lights <= lamp_r;
        end
    end

endmodule

// File: tb/tb_tbird_sweep.sv
// Self-checking bench for tbird_sweep (LAMPS=3, DIV=4).
// Compares lamps against a sweep/flash model built from the behaviour rules.
module tb_tbird_sweep;

    localparam int LAMPS = 3;
    localparam int DIV   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             left = 1'b0;
    logic             right = 1'b0;
    logic             hazard = 1'b0;
`ifdef TBIRD_BRAKE_EN
    logic             brake = 1'b0;
`endif
    logic [LAMPS-1:0] left_lights;
    logic [LAMPS-1:0] right_lights;
    logic             step;

    int n_checks = 0;
    int n_fail   = 0;

    tbird_sweep #(
        .LAMPS   (LAMPS),
        .CLK_HZ  (8),
        .STEP_HZ (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .left         (left),
        .right        (right),
        .hazard       (hazard),
`ifdef TBIRD_BRAKE_EN
        .brake        (brake),
`endif
        .left_lights  (left_lights),
        .right_lights (right_lights),
        .step         (step)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model: which side is sweeping, how many lamps lit, hazard flash phase.
    int               m_side;
    int               m_lit;
    bit               m_flash;
    bit               m_on;
    logic [LAMPS-1:0] exp_l;
    logic [LAMPS-1:0] exp_r;

    function automatic logic [LAMPS-1:0] lit_mask(input int n);
        int v;
        v = (1 << n) - 1;
        return LAMPS'(v);
    endfunction

    task automatic model_out();
        logic [LAMPS-1:0] full;
        full = '1;
        exp_l = m_on ? full : '0;
        exp_r = m_on ? full : '0;
        if (m_side == 1) exp_l = lit_mask(m_lit);
        if (m_side == 2) exp_r = lit_mask(m_lit) << (LAMPS - m_lit);
    endtask

    task automatic model_reset();
        m_side  = 0;
        m_lit   = 0;
        m_flash = 0;
        m_on    = 0;
        model_out();
    endtask

    task automatic model_step(input bit l, input bit r, input bit h);
        int want;
        bit was_flash;
        was_flash = m_flash;
        if (h || (l && r)) begin
            m_side = 0;
            m_lit  = 0;
            m_on   = was_flash ? !m_on : 1'b1;
            m_flash = 1;
        end else begin
            m_flash = 0;
            m_on    = 0;
            want = l ? 1 : (r ? 2 : 0);
            if (was_flash || want == 0) begin
                m_side = 0;
                m_lit  = 0;
            end else if (m_side == 0) begin
                m_side = want;
                m_lit  = 1;
            end else if (m_side == want && m_lit < LAMPS) begin
                m_lit = m_lit + 1;
            end else begin
                m_side = 0;
                m_lit  = 0;
            end
        end
        model_out();
    endtask

    task automatic apply_reset(input bit l, input bit r, input bit h);
        rst = 1'b1;
        left = l;
        right = r;
        hazard = h;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Drive a request for one full step and leave time 1 after the tick edge.
    task automatic do_step(input bit l, input bit r, input bit h);
        left = l;
        right = r;
        hazard = h;
        model_step(l, r, h);
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        left = 1'b1;
        #1;
        n_checks++;
        if ({left_lights, right_lights, step} !== '0)
            $display("FAIL reset_state: got %b/%b/%b want 000/000/0",
                     left_lights, right_lights, step);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        model_step(1, 0, 0);
        for (int k = 1; k < DIV; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (step !== 1'b0 || left_lights !== '0) begin
                n_fail++;
                $display("FAIL first_wait: clk %0d step=%b left=%b want 0/000",
                         k, step, left_lights);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (step !== 1'b1 || left_lights !== exp_l || right_lights !== exp_r) begin
            n_fail++;
            $display("FAIL first_step: got %b/%b/%b want %b/%b/1",
                     left_lights, right_lights, step, exp_l, exp_r);
        end
    endtask

    task automatic test_left_sweep();
        logic [LAMPS-1:0] want [7];
        want = '{3'b011, 3'b111, 3'b000, 3'b001, 3'b011, 3'b111, 3'b000};
        for (int s = 0; s < 7; s++) begin
            do_step(1, 0, 0);
            n_checks++;
            if (left_lights !== want[s] || left_lights !== exp_l ||
                right_lights !== 3'b000 || step !== 1'b1) begin
                n_fail++;
                $display("FAIL left_sweep: step %0d got %b/%b/%b want %b/000/1",
                         s, left_lights, right_lights, step, want[s]);
            end
        end
    endtask

    task automatic test_release();
        apply_reset(1, 0, 0);
        do_step(1, 0, 0);
        do_step(1, 0, 0);
        for (int s = 0; s < 3; s++) begin
            do_step(0, 0, 0);
            n_checks++;
            if (left_lights !== exp_l || right_lights !== exp_r) begin
                n_fail++;
                $display("FAIL release: step %0d got %b/%b want %b/%b",
                         s, left_lights, right_lights, exp_l, exp_r);
            end
        end
    endtask

    task automatic test_hazard();
        bit [2:0] seq [9];
        seq = '{3'b010, 3'b010, 3'b011, 3'b011, 3'b011,
                3'b110, 3'b110, 3'b000, 3'b000};
        apply_reset(0, 1, 0);
        for (int s = 0; s < 9; s++) begin
            do_step(seq[s][2], seq[s][1], seq[s][0]);
            n_checks++;
            if (left_lights !== exp_l || right_lights !== exp_r || step !== 1'b1) begin
                n_fail++;
                $display("FAIL hazard: step %0d got %b/%b want %b/%b",
                         s, left_lights, right_lights, exp_l, exp_r);
            end
        end
    endtask

    task automatic test_latency();
        apply_reset(0, 0, 0);
        do_step(0, 0, 0);
        repeat (DIV - 1) @(posedge clk);
        #1;
        left = 1'b1;
        model_step(0, 0, 0);
        @(posedge clk);
        #1;
        n_checks++;
        if (left_lights !== exp_l || step !== 1'b1) begin
            n_fail++;
            $display("FAIL late_input: got %b step=%b want %b", left_lights, step, exp_l);
        end
        do_step(1, 0, 0);
        n_checks++;
        if (left_lights !== exp_l || exp_l !== 3'b001) begin
            n_fail++;
            $display("FAIL late_next: got %b want 001", left_lights);
        end
    endtask

    task automatic test_glitch();
        apply_reset(0, 0, 0);
        do_step(0, 0, 0);
        hazard = 1'b1;
        model_step(0, 0, 0);
        @(posedge clk);
        #1;
        hazard = 1'b0;
        repeat (DIV - 1) @(posedge clk);
        #1;
        n_checks++;
        if (left_lights !== exp_l || right_lights !== exp_r || step !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch: got %b/%b want %b/%b",
                     left_lights, right_lights, exp_l, exp_r);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(1, 0, 0);
        do_step(1, 0, 0);
        do_step(1, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({left_lights, right_lights, step} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b/%b/%b want 000/000/0",
                     left_lights, right_lights, step);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_step(1, 0, 0);
        n_checks++;
        if (left_lights !== 3'b001 || step !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_restart: got %b step=%b want 001/1", left_lights, step);
        end
    endtask

    task automatic test_random();
        bit l, r, h;
        apply_reset(0, 0, 0);
        l = 0;
        r = 0;
        h = 0;
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                l = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
                h = ($urandom_range(0, 4) == 0);
            end
            do_step(l, r, h);
            n_checks++;
            if (left_lights !== exp_l || right_lights !== exp_r || step !== 1'b1) begin
                n_fail++;
                $display("FAIL random: step %0d in=%b%b%b got %b/%b want %b/%b",
                         s, l, r, h, left_lights, right_lights, exp_l, exp_r);
            end
        end
    endtask

`ifdef TBIRD_BRAKE_EN
    task automatic test_brake();
        bit seen;
        apply_reset(0, 0, 0);
        do_step(0, 0, 0);
        brake = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (left_lights !== 3'b000 || right_lights !== 3'b000) begin
            n_fail++;
            $display("FAIL brake_early: got %b/%b want 000/000", left_lights, right_lights);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (left_lights !== 3'b111 || right_lights !== 3'b111) begin
            n_fail++;
            $display("FAIL brake_on: got %b/%b want 111/111", left_lights, right_lights);
        end
        brake = 1'b0;
        seen = 0;
        for (int k = 0; k < 2 * DIV && !seen; k++) begin
            @(posedge clk);
            #1;
            seen = step;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL brake_realign: step=0 want 1 within %0d clk", 2 * DIV);
        end
        do_step(0, 0, 0);
        n_checks++;
        if (left_lights !== 3'b000 || right_lights !== 3'b000) begin
            n_fail++;
            $display("FAIL brake_off: got %b/%b want 000/000", left_lights, right_lights);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_left_sweep();
        test_release();
        test_hazard();
        test_latency();
        test_glitch();
        test_reset_mid();
        test_random();
`ifdef TBIRD_BRAKE_EN
        test_brake();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
